// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with hex decode and a
// double-buffered display value. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 100,
  parameter bit SEG_INV      = 1'b0,
  parameter bit COM_INV      = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*N_DIGITS-1:0]   i_value,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic                    i_load,
  input  logic                    i_blank,
  output logic [7:0]              o_segs,
  output logic [N_DIGITS-1:0]     o_com,
  output logic                    o_frame
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0]       SLOT_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_XOR    = SEG_INV ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] COM_XOR    = COM_INV ? '1 : '0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                r_state, w_state_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic                  w_frame_nxt;

  logic [4*N_DIGITS-1:0] r_shadow_val, r_act_val, w_act_val_nxt;
  logic [N_DIGITS-1:0]   r_shadow_dp, r_act_dp, w_act_dp_nxt;
  logic                  r_pending;

  logic [7:0]            r_segs, w_segs_nxt;
  logic [N_DIGITS-1:0]   r_com, w_com_nxt;
  logic                  r_frame;
  logic [3:0]            w_nib;
  logic [6:0]            w_glyph;
  logic [IW-1:0]         w_msd;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_idx_nxt   = r_idx;
    w_frame_nxt = 1'b0;
    case (r_state)
      ST_BLANK: if (r_timer == BLANK_LAST) w_state_nxt = ST_SHOW;
      default: begin
        if (r_timer == SLOT_LAST) begin
          w_state_nxt = ST_BLANK;
          w_timer_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_frame_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  // Active buffer swaps on the edge that closes the o_frame cycle; a load on
  // that same edge bypasses the shadow.
  always_comb begin
    w_act_val_nxt = r_act_val;
    w_act_dp_nxt  = r_act_dp;
    if (r_frame) begin
      if (i_load) begin
        w_act_val_nxt = i_value;
        w_act_dp_nxt  = i_dp;
      end else if (r_pending) begin
        w_act_val_nxt = r_shadow_val;
        w_act_dp_nxt  = r_shadow_dp;
      end
    end
  end

  always_comb begin
    w_msd = '0;
    for (int k = 1; k < N_DIGITS; k++)
      if (w_act_val_nxt[4*k +: 4] != 4'h0) w_msd = IW'(k);
  end

  always_comb begin
    w_nib   = w_act_val_nxt[4*w_idx_nxt +: 4];
    w_glyph = hex_glyph(w_nib);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_idx_nxt > w_msd) w_glyph = 7'h00;
`endif
    w_segs_nxt = 8'h00;
    w_com_nxt  = '0;
    if (w_state_nxt == ST_SHOW) begin
      w_segs_nxt = {w_act_dp_nxt[w_idx_nxt], w_glyph};
      if (!i_blank) w_com_nxt = N_DIGITS'(1) << w_idx_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_BLANK;
      r_timer      <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_segs       <= SEG_XOR;
      r_com        <= COM_XOR;
      r_frame      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_idx     <= w_idx_nxt;
      r_act_val <= w_act_val_nxt;
      r_act_dp  <= w_act_dp_nxt;
      if (i_load) begin
        r_shadow_val <= i_value;
        r_shadow_dp  <= i_dp;
      end
      if (r_frame)     r_pending <= 1'b0;
      else if (i_load) r_pending <= 1'b1;
      r_segs  <= w_segs_nxt ^ SEG_XOR;
      r_com   <= w_com_nxt ^ COM_XOR;
      r_frame <= w_frame_nxt;
    end
  end

  assign o_segs  = r_segs;
  assign o_com   = r_com;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + random bench for seg7_scan_driver; a cycle-indexed reference model
// checks a normal and an inverted-polarity instance every clock.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * SD;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  value = '0;
  logic [3:0]   dp = '0;
  logic         load = 1'b0;
  logic         blank = 1'b0;
  logic [7:0]   segs, segs_n;
  logic [3:0]   com, com_n;
  logic         frame, frame_n;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int           cyc;
  logic [15:0]  m_shadow_v, m_act_v;
  logic [3:0]   m_shadow_dp, m_act_dp;
  logic         m_pend, m_blank_q;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                     .SEG_INV(1'b0), .COM_INV(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_load(load),
    .i_blank(blank), .o_segs(segs), .o_com(com), .o_frame(frame));

  seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                     .SEG_INV(1'b1), .COM_INV(1'b1)) dut_inv (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_load(load),
    .i_blank(blank), .o_segs(segs_n), .o_com(com_n), .o_frame(frame_n));

  task automatic model_reset();
    cyc = 0;
    m_shadow_v = '0; m_shadow_dp = '0; m_pend = 1'b0;
    m_act_v = '0; m_act_dp = '0; m_blank_q = 1'b0;
  endtask

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    int pos, d;
    logic [15:0] upper;
    logic [6:0]  g;
    logic [7:0]  e_segs;
    logic [3:0]  e_com;
    logic        e_frame;
    pos   = cyc % SD;
    d     = (cyc / SD) % N;
    upper = m_act_v >> (4 * d);
    g     = GLYPH[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0) g = 7'h00;
`endif
    e_frame = (cyc > 0) && (cyc % FRAME == 0);
    e_segs  = (pos >= BC) ? {m_act_dp[d], g} : 8'h00;
    e_com   = (pos >= BC && !m_blank_q) ? 4'(1 << d) : 4'h0;
    cmp("segs",    segs,             e_segs);
    cmp("com",     {4'h0, com},      {4'h0, e_com});
    cmp("frame",   {7'h0, frame},    {7'h0, e_frame});
    cmp("segs_inv", segs_n,          ~e_segs);
    cmp("com_inv", {4'h0, com_n},    {4'h0, ~e_com});
    cmp("frame_inv", {7'h0, frame_n}, {7'h0, e_frame});
  endtask

  // One clock: the model consumes the inputs present at the edge, then outputs are checked.
  task automatic tick();
    @(posedge clk);
    if (cyc > 0 && cyc % FRAME == 0 && (load || m_pend)) begin
      m_act_v  = load ? value : m_shadow_v;
      m_act_dp = load ? dp    : m_shadow_dp;
      m_pend   = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin
      m_shadow_v  = value;
      m_shadow_dp = dp;
    end
    m_blank_q = blank;
    cyc++;
    #1 check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value = v; dp = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic to_frame_pos(input int p);
    for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_outputs();
    run(12);

    // Asynchronous reset in the middle of a SHOW period.
    to_frame_pos(SD + 4);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_segs", segs, 8'h00);
    cmp("async_rst_com",  {4'h0, com}, 8'h00);
    cmp("async_rst_segs_inv", segs_n, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check_outputs();
    run(FRAME + 8);

    do_load(16'h12AF, 4'h0);
    run(2 * FRAME);

    do_load(16'h1234, 4'h0);
    to_frame_pos(0);
    run(1);
    to_frame_pos(10);
    do_load(16'h5678, 4'h0);
    run(FRAME + 8);

    // Load coinciding with the o_frame cycle goes straight to active.
    to_frame_pos(0);
    do_load(16'h0009, 4'h0);
    run(FRAME);

    do_load(16'hBEEF, 4'b0100);
    run(2 * FRAME);
    to_frame_pos(0);
    blank = 1'b1;
    run(FRAME);
    blank = 1'b0;
    run(FRAME);

    do_load(16'h0030, 4'b1010);
    run(2 * FRAME);
    do_load(16'h0000, 4'h0);
    run(2 * FRAME);

    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 11) == 0);
      if (load) begin
        value = 16'($urandom);
        if ($urandom_range(0, 2) == 0) value = value >> (4 * $urandom_range(1, 3));
        dp = 4'($urandom);
      end
      if ($urandom_range(0, 47) == 0) blank = ~blank;
      tick();
    end
    load = 1'b0;
    blank = 1'b0;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
